sdram_s1_responder: RTL and testbench
=====================================

SDRAM_S1_RESPONDER -- requirements
Module: sdram_s1_responder

Interface
REQ-001 The block SHALL provide parameter MEM_ADDR_BITS, default 8: number of low address bits decoded; memory depth is 2^MEM_ADDR_BITS 32-bit words.
REQ-002 The block SHALL provide parameter RD_LATENCY, default 3: cycles from read acceptance to readdatavalid; legal range 1..8.
REQ-003 The block SHALL provide parameter MAX_PENDING, default 2: maximum reads accepted but not yet returned; legal range 1..RD_LATENCY.
REQ-004 The block SHALL provide parameter REFRESH_PERIOD, default 64: cycles between refresh windows.
REQ-005 The block SHALL provide parameter REFRESH_LEN, default 4: cycles per refresh window.
REQ-006 The block SHALL have port i_clk, input, 1 bit: sole clock, rising edge.
REQ-007 The block SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 The block SHALL have port s1_address, input, 23 bits: word address.
REQ-009 The block SHALL have port s1_byteenable_n, input, 4 bits: active-low byte lane enables for writes.
REQ-010 The block SHALL have port s1_chipselect, input, 1 bit: transfer qualifier.
REQ-011 The block SHALL have port s1_writedata, input, 32 bits: write data.
REQ-012 The block SHALL have port s1_read_n, input, 1 bit: active-low read request.
REQ-013 The block SHALL have port s1_write_n, input, 1 bit: active-low write request.
REQ-014 The block SHALL have port s1_readdata, output, 32 bits: read return data.
REQ-015 The block SHALL have port s1_readdatavalid, output, 1 bit: s1_readdata is valid this cycle.
REQ-016 The block SHALL have port s1_waitrequest, output, 1 bit: request not accepted this cycle.
REQ-017 The block SHALL have port o_protocol_err, output, 1 bit: sticky protocol violation flag.
REQ-018 The block SHALL have port o_rd_count, output, 16 bits: saturating count of accepted reads.
REQ-019 The block SHALL have port o_wr_count, output, 16 bits: saturating count of accepted writes.

Function
REQ-020 Waitrequest SHALL be decoded from registered state only, with s1_waitrequest = (state==REFRESH) || (pending==MAX_PENDING); it SHALL NOT depend combinationally on any input.
REQ-021 A write SHALL be accepted on a rising edge with chipselect=1, write_n=0 and waitrequest=0; each byte lane i with byteenable_n[i]=0 SHALL be updated at mem[address[MEM_ADDR_BITS-1:0]].
REQ-022 A read SHALL be accepted on a rising edge with chipselect=1, read_n=0, write_n=1 and waitrequest=0; memory SHALL be sampled in the acceptance cycle, and readdatavalid SHALL rise exactly RD_LATENCY cycles later for exactly one cycle.
REQ-023 Reads SHALL return in acceptance order; back-to-back accepted reads SHALL produce back-to-back valid cycles.
REQ-024 A read accepted in the cycle after a write to the same address SHALL return the new data.
REQ-025 pending SHALL increment on read accept and decrement on read return; a simultaneous accept and return SHALL leave pending unchanged.
REQ-026 Read_n=0 and write_n=0 together with chipselect=1 and waitrequest=0 SHALL perform the write only, drop the read, and set o_protocol_err until reset.
REQ-027 The state machine SHALL have two states: ACTIVE, and REFRESH entered when the 16-bit cycle counter reaches REFRESH_PERIOD-1, the counter then restarting at 0.
REQ-028 The block SHALL leave REFRESH after REFRESH_LEN cycles; in-flight reads SHALL continue to return during REFRESH.
REQ-029 When readdatavalid=0, s1_readdata SHALL hold its last value.
REQ-030 Counters SHALL saturate at 16'hFFFF.

Reset
REQ-031 Reset SHALL set state=ACTIVE, refresh counter=0, pending=0, read pipeline empty, readdatavalid=0, readdata=0, waitrequest=0, o_protocol_err=0, o_rd_count=0 and o_wr_count=0.
REQ-032 Reset mid-operation SHALL discard in-flight reads with no readdatavalid afterward; memory contents SHALL NOT be cleared.
REQ-033 Requests presented while i_rst=1 SHALL be ignored.

Structure
REQ-034 A shared package sdram_pkg SHALL hold the state enum (ACTIVE, REFRESH) and the constants DATA_W=32, ADDR_W=23 and BE_W=4.
REQ-035 One sub-module, sdram_rd_pipe, SHALL implement the RD_LATENCY-stage valid/data shift pipeline; the memory array and FSM SHALL stay in the top module.

Verification
REQ-036 Scenario: write 32'h075D2A60 to address 5 with byteenable_n=0, then read address 5 -> readdatavalid exactly 3 cycles after acceptance with readdata=32'h075D2A60; o_wr_count=1 and o_rd_count=1.
REQ-037 Scenario: write 32'hFFFFFFFF to address 9, then write 32'h00001234 with byteenable_n=4'b1100, then read -> readdata=32'hFFFF1234.
REQ-038 Scenario: hold read_n=0 on addresses 0,1,2,3 -> waitrequest rises once pending=2; all four reads return in order, with waitrequest deasserting as returns occur.
REQ-039 Scenario: idle after reset -> waitrequest high on cycles 64..67 and 132..135 after reset release; a read held across the window is accepted on cycle 68.
REQ-040 Scenario: read_n=0 and write_n=0 together on address 7 with data 32'hA5A5A5A5 -> mem[7] updated, no readdatavalid, and o_protocol_err=1 until reset.
REQ-041 Scenario: accept a read, assert i_rst one cycle later for 2 cycles -> no readdatavalid afterward, all outputs at reset values, and mem[5] still readable as its prior value.

Source files
------------

// File: rtl/sdram_s1_responder_pkg.sv
// Shared types and constants for the SDRAM s1 slave responder.
package sdram_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 23;
    localparam int BE_W   = 4;

    typedef enum logic {
        ACTIVE,
        REFRESH
    } state_e;

    // Replace only the byte lanes whose active-low enable is asserted.
    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be_n
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (!be_n[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sdram_s1_responder_if.sv
// Avalon-style s1 slave bus between a master and the SDRAM responder.
interface sdram_s1_if;
    import sdram_pkg::*;

    logic [ADDR_W-1:0] s1_address;
    logic [BE_W-1:0]   s1_byteenable_n;
    logic              s1_chipselect;
    logic [DATA_W-1:0] s1_writedata;
    logic              s1_read_n;
    logic              s1_write_n;
    logic [DATA_W-1:0] s1_readdata;
    logic              s1_readdatavalid;
    logic              s1_waitrequest;

    modport master (
        output s1_address, s1_byteenable_n, s1_chipselect, s1_writedata,
               s1_read_n, s1_write_n,
        input  s1_readdata, s1_readdatavalid, s1_waitrequest
    );

    modport slave (
        input  s1_address, s1_byteenable_n, s1_chipselect, s1_writedata,
               s1_read_n, s1_write_n,
        output s1_readdata, s1_readdatavalid, s1_waitrequest
    );

endinterface

// File: rtl/sdram_s1_responder_rd_pipe.sv
// Fixed-latency read return pipeline; the final stage holds its data between returns.
module sdram_rd_pipe
    import sdram_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [DATA_W-1:0]  data_q [LATENCY];
    logic [DATA_W-1:0]  data_d [LATENCY];

    always_comb begin
        valid_d    = valid_q << 1;
        valid_d[0] = i_valid;
        data_d     = data_q;
        data_d[0]  = i_valid ? i_data : data_q[0];
        // Stages only load when a valid word moves in, so the last stage keeps old data.
        for (int unsigned i = 1; i < LATENCY; i++) begin
            if (valid_q[i-1]) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            data_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q[LATENCY-1];
    assign o_data  = data_q[LATENCY-1];

endmodule

// File: rtl/sdram_s1_responder.sv
// SDRAM s1 slave model: word memory, fixed-latency pipelined reads, periodic refresh stalls.
module sdram_s1_responder
    import sdram_pkg::*;
#(
    parameter int MEM_ADDR_BITS  = 8,
    parameter int RD_LATENCY     = 3,
    parameter int MAX_PENDING    = 2,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_LEN    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    sdram_s1_if.slave   s1,
    output logic        o_protocol_err,
    output logic [15:0] o_rd_count,
    output logic [15:0] o_wr_count
);

    localparam int MEM_DEPTH = 1 << MEM_ADDR_BITS;

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [3:0]         pending_q, pending_d;
    logic               proto_err_q, proto_err_d;
    logic [15:0]        rd_count_q, rd_count_d;
    logic [15:0]        wr_count_q, wr_count_d;
    logic [DATA_W-1:0]  mem_q [MEM_DEPTH];

    logic               wait_req;
    logic               req_ok;
    logic               wr_acc;
    logic               rd_acc;
    logic               rd_ret;
    logic [MEM_ADDR_BITS-1:0] idx;
    logic [DATA_W-1:0]  rd_data;
    logic               unused_addr;

    assign idx         = s1.s1_address[MEM_ADDR_BITS-1:0];
    assign unused_addr = ^s1.s1_address[ADDR_W-1:MEM_ADDR_BITS];

    always_comb begin
        wait_req = (state_q == REFRESH) || (pending_q == 4'(MAX_PENDING));
        req_ok   = s1.s1_chipselect && !wait_req && !i_rst;
        // A simultaneous read+write is treated as a write; the read is dropped.
        wr_acc   = req_ok && !s1.s1_write_n;
        rd_acc   = req_ok && !s1.s1_read_n && s1.s1_write_n;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        case (state_q)
            ACTIVE: begin
                if (cnt_q == 16'(REFRESH_PERIOD - 1)) begin
                    state_d = REFRESH;
                    cnt_d   = '0;
                end
            end
            REFRESH: begin
                if (cnt_q == 16'(REFRESH_LEN - 1)) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        case ({rd_acc, rd_ret})
            2'b10:   pending_d = pending_q + 4'd1;
            2'b01:   pending_d = pending_q - 4'd1;
            default: pending_d = pending_q;
        endcase

        proto_err_d = proto_err_q || (wr_acc && !s1.s1_read_n);
        rd_count_d  = (rd_acc && (rd_count_q != '1)) ? rd_count_q + 16'd1 : rd_count_q;
        wr_count_d  = (wr_acc && (wr_count_q != '1)) ? wr_count_q + 16'd1 : wr_count_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ACTIVE;
            cnt_q       <= '0;
            pending_q   <= '0;
            proto_err_q <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            proto_err_q <= proto_err_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    // Memory survives reset; only accepted writes touch it.
    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem_q[idx] <= be_merge(mem_q[idx], s1.s1_writedata, s1.s1_byteenable_n);
        end
    end

    sdram_rd_pipe #(
        .LATENCY(RD_LATENCY)
    ) u_rd_pipe (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(rd_acc),
        .i_data (mem_q[idx]),
        .o_valid(rd_ret),
        .o_data (rd_data)
    );

    assign s1.s1_readdata      = rd_data;
    assign s1.s1_readdatavalid = rd_ret;
    assign s1.s1_waitrequest   = wait_req;
    assign o_protocol_err      = proto_err_q;
    assign o_rd_count          = rd_count_q;
    assign o_wr_count          = wr_count_q;

endmodule

// File: tb/tb_sdram_s1_responder.sv
// Self-checking bench for sdram_s1_responder against a cycle-indexed reference model.
module tb_sdram_s1_responder;
    import sdram_pkg::*;

    localparam int MAB   = 8;
    localparam int LAT   = 3;
    localparam int MAXP  = 2;
    localparam int RP    = 64;
    localparam int RL    = 4;
    localparam int DEPTH = 1 << MAB;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        proto_err;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    sdram_s1_if bus ();

    sdram_s1_responder #(
        .MEM_ADDR_BITS (MAB),
        .RD_LATENCY    (LAT),
        .MAX_PENDING   (MAXP),
        .REFRESH_PERIOD(RP),
        .REFRESH_LEN   (RL)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .s1            (bus),
        .o_protocol_err(proto_err),
        .o_rd_count    (rd_cnt),
        .o_wr_count    (wr_cnt)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic        last_acc = 1'b0;
    logic [31:0] mdl_mem [DEPTH];
    rd_t         q [$];
    logic [31:0] last_data = '0;
    logic        exp_perr = 1'b0;
    int          exp_rd = 0;
    int          exp_wr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdl_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be_n);
        logic [31:0] mask;
        mask = {{8{~be_n[3]}}, {8{~be_n[2]}}, {8{~be_n[1]}}, {8{~be_n[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // One clock: predict acceptance, apply to model, advance, then check outputs.
    task automatic step();
        logic w;
        logic exp_v;
        int   a;
        w = ((cyc % (RP + RL)) >= RP) || (q.size() == MAXP);
        last_acc = 1'b0;
        if (!rst) begin
            chk("waitrequest", 32'(bus.s1_waitrequest), 32'(w));
            a = int'(bus.s1_address[MAB-1:0]);
            if (!w && bus.s1_chipselect) begin
                if (!bus.s1_write_n) begin
                    mdl_mem[a] = mdl_merge(mdl_mem[a], bus.s1_writedata, bus.s1_byteenable_n);
                    if (exp_wr < 65535) exp_wr++;
                    if (!bus.s1_read_n) exp_perr = 1'b1;
                    last_acc = 1'b1;
                    acc_cyc  = cyc;
                end else if (!bus.s1_read_n) begin
                    q.push_back('{due: cyc + LAT, data: mdl_mem[a]});
                    if (exp_rd < 65535) exp_rd++;
                    last_acc = 1'b1;
                    acc_cyc  = cyc;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            exp_rd    = 0;
            exp_wr    = 0;
            exp_perr  = 1'b0;
            last_data = '0;
            cyc       = 0;
        end else begin
            cyc++;
        end
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        exp_v = (q.size() > 0) && (q[0].due == cyc);
        chk("readdatavalid", 32'(bus.s1_readdatavalid), 32'(exp_v));
        if (exp_v) begin
            chk("readdata", bus.s1_readdata, q[0].data);
            last_data = q[0].data;
        end else begin
            chk("readdata_hold", bus.s1_readdata, last_data);
        end
        chk("protocol_err", 32'(proto_err), 32'(exp_perr));
        chk("rd_count", 32'(rd_cnt), exp_rd);
        chk("wr_count", 32'(wr_cnt), exp_wr);
    endtask

    task automatic idle_bus();
        bus.s1_chipselect   = 1'b0;
        bus.s1_read_n       = 1'b1;
        bus.s1_write_n      = 1'b1;
        bus.s1_byteenable_n = 4'hF;
    endtask

    task automatic idle(input int n);
        idle_bus();
        repeat (n) step();
    endtask

    task automatic xfer(input bit rd, input bit wr, input logic [22:0] addr,
                        input logic [31:0] data, input logic [3:0] be_n);
        bus.s1_chipselect   = 1'b1;
        bus.s1_read_n       = ~rd;
        bus.s1_write_n      = ~wr;
        bus.s1_address      = addr;
        bus.s1_writedata    = data;
        bus.s1_byteenable_n = be_n;
        for (int k = 0; k < 40; k++) begin
            step();
            if (last_acc) break;
        end
        chk("accept_timeout", 32'(last_acc), 32'd1);
        idle_bus();
    endtask

    task automatic wait_valid(input string tag, input int acc, input logic [31:0] exp_data);
        for (int k = 0; k < 12; k++) begin
            if (bus.s1_readdatavalid) break;
            step();
        end
        chk({tag, "_latency"}, cyc - acc, LAT);
        chk({tag, "_data"}, bus.s1_readdata, exp_data);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] v;
        int          a0;
        bus.s1_address   = '0;
        bus.s1_writedata = '0;
        idle_bus();
        do_reset(3);

        // Known contents everywhere so any read has a defined expectation.
        for (int a = 0; a < DEPTH; a++) begin
            xfer(1'b0, 1'b1, 23'(a), $urandom, 4'h0);
        end

        // Basic write then read, fresh counters.
        do_reset(2);
        chk("reset_rd_count", 32'(rd_cnt), 32'd0);
        chk("reset_wait", 32'(bus.s1_waitrequest), 32'd0);
        xfer(1'b0, 1'b1, 23'd5, 32'h075D2A60, 4'h0);
        xfer(1'b1, 1'b0, 23'd5, 32'h0, 4'hF);
        a0 = acc_cyc;
        wait_valid("s36", a0, 32'h075D2A60);
        chk("s36_wr_count", 32'(wr_cnt), 32'd1);
        chk("s36_rd_count", 32'(rd_cnt), 32'd1);
        idle(3);

        // Byte-lane merge.
        xfer(1'b0, 1'b1, 23'd9, 32'hFFFFFFFF, 4'h0);
        xfer(1'b0, 1'b1, 23'd9, 32'h00001234, 4'b1100);
        xfer(1'b1, 1'b0, 23'd9, 32'h0, 4'hF);
        a0 = acc_cyc;
        wait_valid("s37", a0, 32'hFFFF1234);
        idle(3);

        // Held reads saturate the pending limit.
        xfer(1'b1, 1'b0, 23'd0, 32'h0, 4'hF);
        xfer(1'b1, 1'b0, 23'd1, 32'h0, 4'hF);
        chk("s38_wait_full", 32'(bus.s1_waitrequest), 32'd1);
        xfer(1'b1, 1'b0, 23'd2, 32'h0, 4'hF);
        xfer(1'b1, 1'b0, 23'd3, 32'h0, 4'hF);
        idle(6);
        chk("s38_drained_wait", 32'(bus.s1_waitrequest), 32'd0);

        // Refresh windows relative to reset release.
        do_reset(2);
        idle(64);
        chk("s39_cycle", cyc, 64);
        chk("s39_wait64", 32'(bus.s1_waitrequest), 32'd1);
        xfer(1'b1, 1'b0, 23'd7, 32'h0, 4'hF);
        chk("s39_accept_cycle", acc_cyc, 68);
        idle(132 - cyc);
        for (int k = 0; k < 4; k++) begin
            chk("s39_wait132", 32'(bus.s1_waitrequest), 32'd1);
            step();
        end
        chk("s39_wait136", 32'(bus.s1_waitrequest), 32'd0);

        // Random traffic, including write followed by read of the same word.
        for (int n = 0; n < 250; n++) begin
            logic [22:0] ad;
            int          kind;
            ad = 23'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) ad = ad | (23'($urandom) & 23'h7FFF00);
            kind = $urandom_range(0, 3);
            case (kind)
                0: idle($urandom_range(1, 3));
                1: xfer(1'b0, 1'b1, ad, $urandom, 4'($urandom));
                2: xfer(1'b1, 1'b0, ad, 32'h0, 4'hF);
                default: begin
                    xfer(1'b0, 1'b1, ad, $urandom, 4'($urandom));
                    xfer(1'b1, 1'b0, ad, 32'h0, 4'hF);
                end
            endcase
        end
        idle(6);

        // Simultaneous read and write: write only, sticky error.
        xfer(1'b1, 1'b1, 23'd7, 32'hA5A5A5A5, 4'h0);
        idle(6);
        chk("s40_perr", 32'(proto_err), 32'd1);
        xfer(1'b1, 1'b0, 23'd7, 32'h0, 4'hF);
        a0 = acc_cyc;
        wait_valid("s40_mem7", a0, 32'hA5A5A5A5);
        idle(3);
        chk("s40_perr_sticky", 32'(proto_err), 32'd1);

        // Reset with a read in flight; a write presented during reset is ignored.
        v = mdl_mem[5];
        xfer(1'b1, 1'b0, 23'd5, 32'h0, 4'hF);
        bus.s1_chipselect   = 1'b1;
        bus.s1_write_n      = 1'b0;
        bus.s1_address      = 23'd5;
        bus.s1_writedata    = ~v;
        bus.s1_byteenable_n = 4'h0;
        do_reset(2);
        idle(6);
        chk("s41_perr", 32'(proto_err), 32'd0);
        chk("s41_readdata", bus.s1_readdata, 32'd0);
        chk("s41_wr_count", 32'(wr_cnt), 32'd0);
        xfer(1'b1, 1'b0, 23'd5, 32'h0, 4'hF);
        a0 = acc_cyc;
        wait_valid("s41_mem5", a0, v);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
